// File: rtl/dma_read_master.sv
// ----------------------------------------------------------------------------
// dma_read_master
//
// Purpose: turns one [start, end) byte-range command into a sequence of
// incrementing 32-bit AXI read bursts (at most MAX_BURST beats, never
// crossing a 4 KB page) and forwards the returned words unchanged to a
// valid/ready word stream. Only one burst is in flight at a time.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready     command handshake; ready only while idle
//   cmd_addr_start/end  byte range [start, end); start is word-aligned down
//   AR*                 AXI read-address channel (ARSIZE=4 bytes, INCR)
//   R*                  AXI read-data channel; RREADY follows out_ready
//   out_valid/ready     word stream, combinational pass-through of R
//   out_data            returned RDATA
//   done                one-cycle pulse when the command has completed
//   err                 sticky error (RRESP/RID/RLAST), cleared on accept
// ----------------------------------------------------------------------------

`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module dma_read_master #(
    parameter int unsigned MAX_BURST = 16,
    parameter logic [3:0]  ARID_VAL  = 4'h0
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [`AXI_ADDR_BITS-1:0] cmd_addr_start,
    input  logic [`AXI_ADDR_BITS-1:0] cmd_addr_end,

    output logic [3:0]                ARID,
    output logic [`AXI_ADDR_BITS-1:0] ARADDR,
    output logic [3:0]                ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    output logic                      ARVALID,
    input  logic                      ARREADY,

    input  logic [3:0]                RID,
    input  logic [`AXI_DATA_BITS-1:0] RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RLAST,
    input  logic                      RVALID,
    output logic                      RREADY,

    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [`AXI_DATA_BITS-1:0] out_data,

    output logic                      done,
    output logic                      err
);

    localparam int unsigned AW = `AXI_ADDR_BITS;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StDone
    } state_e;

    state_e        r_state;
    state_e        w_state_next;

    logic [AW-1:0] r_addr;       // address of the next word to request
    logic [31:0]   r_remaining;  // words still to be received
    logic [4:0]    r_beat_cnt;   // beats received in the current burst
    logic [4:0]    r_beats;      // length of the current burst in beats
    logic          r_err;

    logic [AW-1:0] w_span;
    logic [31:0]   w_cmd_words;
    logic [10:0]   w_room_words;
    logic [4:0]    w_beats;
    logic          w_accept;
    logic          w_ar_hs;
    logic          w_r_hs;
    logic          w_last_beat;
    logic [31:0]   w_rem_dec;
    logic          w_beat_err;

    // ------------------------------------------------------------------
    // Command decode: a non-positive span (or one shorter than a word)
    // yields zero words and the command completes without any AR.
    // ------------------------------------------------------------------
    always_comb begin
        w_span      = cmd_addr_end - cmd_addr_start;
        w_cmd_words = '0;
        if (cmd_addr_end > cmd_addr_start) begin
            w_cmd_words = 32'(w_span >> 2);
        end
    end

    // Words left before the next 4 KB page. An address in the last word of
    // the 32-bit space also sees a page end here, so wrap is covered.
    assign w_room_words = 11'((13'd4096 - {1'b0, r_addr[11:0]}) >> 2);

    // Burst length = min(MAX_BURST, remaining, room in page).
    always_comb begin
        w_beats = 5'(MAX_BURST);
        if (r_remaining < 32'(w_beats)) begin
            w_beats = r_remaining[4:0];
        end
        if ({21'b0, w_room_words} < 32'(w_beats)) begin
            w_beats = w_room_words[4:0];
        end
    end

    assign w_accept    = (r_state == StIdle) && cmd_valid;
    assign w_ar_hs     = (r_state == StAddr) && ARREADY;
    assign w_r_hs      = (r_state == StData) && RVALID && out_ready;
    assign w_last_beat = (r_beat_cnt == (r_beats - 5'd1));
    assign w_rem_dec   = r_remaining - 32'd1;

    // The beat counter, not RLAST, ends a burst; RLAST disagreement is only
    // reported through err.
    assign w_beat_err  = (RLAST != w_last_beat) || (RRESP != 2'b00) || (RID != ARID_VAL);

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        ARVALID      = 1'b0;
        RREADY       = 1'b0;
        out_valid    = 1'b0;
        done         = 1'b0;

        unique case (r_state)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_next = (w_cmd_words == 32'd0) ? StDone : StAddr;
                end
            end
            StAddr: begin
                ARVALID = 1'b1;
                if (ARREADY) begin
                    w_state_next = StData;
                end
            end
            StData: begin
                // Zero-latency pass-through; out_valid never looks at out_ready.
                RREADY    = out_ready;
                out_valid = RVALID;
                if (w_r_hs && w_last_beat) begin
                    w_state_next = (w_rem_dec != 32'd0) ? StAddr : StDone;
                end
            end
            StDone: begin
                done         = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Address-channel fields are registered or derived from registers that
    // do not move while ARVALID is high, so they hold until ARREADY.
    assign ARID     = ARID_VAL;
    assign ARADDR   = r_addr;
    assign ARLEN    = 4'(w_beats - 5'd1);
    assign ARSIZE   = 3'b010;
    assign ARBURST  = 2'b01;
    assign out_data = RDATA;
    assign err      = r_err;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Address, counters and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_beat_cnt  <= '0;
            r_beats     <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr      <= {cmd_addr_start[AW-1:2], 2'b00};
                r_remaining <= w_cmd_words;
                r_err       <= 1'b0;
            end
            if (w_ar_hs) begin
                r_beat_cnt <= '0;
                r_beats    <= w_beats;
            end
            if (w_r_hs) begin
                r_beat_cnt  <= r_beat_cnt + 5'd1;
                r_remaining <= w_rem_dec;
                r_addr      <= r_addr + AW'(4);
                if (w_beat_err) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // Request fields must not change while the slave is stalling.
    a_ar_stable: assert property (@(posedge clk) disable iff (rst)
        (ARVALID && !ARREADY) |=> (ARVALID && $stable(ARADDR) && $stable(ARLEN)));

    // A burst is never requested with nothing left to fetch.
    a_ar_nonempty: assert property (@(posedge clk) disable iff (rst)
        (r_state == StAddr) |-> (r_remaining != 32'd0));

    // No burst is allowed to run past a 4 KB page.
    a_ar_in_page: assert property (@(posedge clk) disable iff (rst)
        ARVALID |-> ({21'b0, w_room_words} >= 32'(w_beats)));
`endif

endmodule

// File: tb/tb_dma_read_master.sv
// ----------------------------------------------------------------------------
// tb_dma_read_master
//
// Table of transfer commands plus randomized commands. The bench plays the
// AXI slave (random ARREADY/RVALID, data derived from the beat address) and
// the word-stream sink, and compares bursts, words, done timing and err
// against a page/burst-splitting model computed from the byte range.
// ----------------------------------------------------------------------------

`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module tb_dma_read_master;

    localparam int MaxBurst = 16;
    localparam int Budget   = 4000;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [`AXI_ADDR_BITS-1:0] cmd_addr_start;
    logic [`AXI_ADDR_BITS-1:0] cmd_addr_end;
    logic [3:0]                ARID;
    logic [`AXI_ADDR_BITS-1:0] ARADDR;
    logic [3:0]                ARLEN;
    logic [2:0]                ARSIZE;
    logic [1:0]                ARBURST;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [3:0]                RID;
    logic [`AXI_DATA_BITS-1:0] RDATA;
    logic [1:0]                RRESP;
    logic                      RLAST;
    logic                      RVALID;
    logic                      RREADY;
    logic                      out_valid;
    logic                      out_ready;
    logic [`AXI_DATA_BITS-1:0] out_data;
    logic                      done;
    logic                      err;

    always #5 clk = ~clk;

    dma_read_master #(
        .MAX_BURST(MaxBurst),
        .ARID_VAL (4'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr_start(cmd_addr_start),
        .cmd_addr_end  (cmd_addr_end),
        .ARID          (ARID),
        .ARADDR        (ARADDR),
        .ARLEN         (ARLEN),
        .ARSIZE        (ARSIZE),
        .ARBURST       (ARBURST),
        .ARVALID       (ARVALID),
        .ARREADY       (ARREADY),
        .RID           (RID),
        .RDATA         (RDATA),
        .RRESP         (RRESP),
        .RLAST         (RLAST),
        .RVALID        (RVALID),
        .RREADY        (RREADY),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .done          (done),
        .err           (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // oready_mode: 0 always ready, 1 toggling, 2 random.
    // err_kind: 0 none, 1 RRESP=SLVERR, 2 wrong RID, 3 inverted RLAST (at err_beat).
    // rst_beat >= 0: assert reset while that beat index is about to be delivered.
    typedef struct {
        logic [31:0] start_a;
        logic [31:0] end_a;
        int          p_ar;
        int          p_rv;
        int          oready_mode;
        int          err_kind;
        int          err_beat;
        int          rst_beat;
        int          exp_bursts;
        int          exp_words;
        bit          exp_err;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] s, input logic [31:0] e, input int par,
                                input int prv, input int orm, input int ek, input int eb,
                                input int rb, input int xb, input int xw, input bit xe);
        vec_t v;
        v.start_a = s;   v.end_a = e;      v.p_ar = par;     v.p_rv = prv;
        v.oready_mode = orm; v.err_kind = ek; v.err_beat = eb; v.rst_beat = rb;
        v.exp_bursts = xb;   v.exp_words = xw; v.exp_err = xe;
        return v;
    endfunction

    // Reference model: split [start, end) into page-bounded bursts.
    logic [31:0] exp_ar_addr[$];
    logic [3:0]  exp_ar_len[$];
    logic [31:0] exp_word_addr[$];

    task automatic model(input logic [31:0] s, input logic [31:0] e);
        logic [31:0] a, rem, room, b;
        exp_ar_addr.delete();
        exp_ar_len.delete();
        exp_word_addr.delete();
        a   = {s[31:2], 2'b00};
        rem = (e > s) ? ((e - s) >> 2) : 32'd0;
        while (rem != 0) begin
            room = (32'd4096 - (a % 32'd4096)) / 32'd4;
            b    = MaxBurst;
            if (rem < b)  b = rem;
            if (room < b) b = room;
            exp_ar_addr.push_back(a);
            exp_ar_len.push_back(4'(b - 32'd1));
            for (int i = 0; i < int'(b); i++) exp_word_addr.push_back(a + 32'(4 * i));
            a   = a + (b << 2);
            rem = rem - b;
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a, input logic [31:0] salt);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    task automatic run_xfer(input vec_t v, input logic [31:0] salt);
        int          cyc, total, beat_idx, words_seen, ndone;
        int          done_bad, attr_bad, proto_bad, mirror_bad, word_bad;
        bit          accepted, pend, rv_hold, exp_done_now, exp_done_next;
        bit          seen_done, chk_err, prev_ar_wait;
        logic        err_at_done;
        logic [31:0] pend_addr, prev_araddr;
        logic [3:0]  pend_len, prev_arlen;
        logic [31:0] got_words[$];
        logic [31:0] ar_addr_got[$];
        logic [3:0]  ar_len_got[$];

        model(v.start_a, v.end_a);
        total = exp_word_addr.size();
        cyc = 0; beat_idx = 0; words_seen = 0; ndone = 0;
        done_bad = 0; attr_bad = 0; proto_bad = 0; mirror_bad = 0; word_bad = 0;
        accepted = 0; pend = 0; rv_hold = 0; exp_done_next = 0; seen_done = 0;
        chk_err = 0; prev_ar_wait = 0; err_at_done = 1'b0;
        pend_addr = '0; pend_len = '0; prev_araddr = '0; prev_arlen = '0;
        cmd_addr_start = v.start_a;
        cmd_addr_end   = v.end_a;

        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc > Budget) begin
                check("xfer_timeout", 64'(seen_done), 64'd1);
                break;
            end
            exp_done_now  = exp_done_next;
            exp_done_next = 0;

            // Drive slave / sink / command inputs for this cycle.
            cmd_valid = !accepted;
            ARREADY   = ($urandom_range(99) < v.p_ar);
            if (!rv_hold) begin
                RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; RID = 4'h0; RDATA = $urandom;
                if (pend && ($urandom_range(99) < v.p_rv ||
                             (v.rst_beat >= 0 && words_seen == v.rst_beat))) begin
                    RVALID = 1'b1;
                    RDATA  = data_of(pend_addr + 32'(4 * beat_idx), salt);
                    RLAST  = (beat_idx == int'(pend_len));
                    if (words_seen == v.err_beat) begin
                        case (v.err_kind)
                            1:       RRESP = 2'b10;
                            2:       RID   = 4'h5;
                            3:       RLAST = !RLAST;
                            default: ;
                        endcase
                    end
                end
            end
            case (v.oready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = ($urandom_range(1) == 1);
            endcase

            // Mid-burst reset: everything must drop in the same cycle.
            if (v.rst_beat >= 0 && pend && words_seen == v.rst_beat) begin
                out_ready = 1'b1;
                rst = 1'b1;
                #1;
                check("rst_mid_burst_outputs", {ARVALID, RREADY, out_valid, done, err}, 5'b0);
                @(negedge clk);
                rst = 1'b0; RVALID = 1'b0; cmd_valid = 1'b0;
                #1;
                check("rst_release_cmd_ready", 64'(cmd_ready), 64'd1);
                return;
            end

            #1;
            if (seen_done) begin
                check("cmd_ready_after_done", 64'(cmd_ready), 64'd1);
                break;
            end
            if (chk_err) begin
                check("err_cleared_on_accept", 64'(err), 64'd0);
                chk_err = 0;
            end
            if (done !== exp_done_now) done_bad++;
            if (done === 1'b1) begin
                ndone++;
                err_at_done = err;
                seen_done   = 1;
            end

            if (RREADY !== (pend ? out_ready : 1'b0)) mirror_bad++;
            if (out_valid !== (pend ? RVALID : 1'b0)) mirror_bad++;
            if (out_valid && out_data !== RDATA) mirror_bad++;

            if (prev_ar_wait && (ARVALID !== 1'b1 || ARADDR !== prev_araddr ||
                                 ARLEN !== prev_arlen)) proto_bad++;
            if (ARVALID && pend) proto_bad++;
            if (ARVALID && (ARSIZE !== 3'b010 || ARBURST !== 2'b01 || ARID !== 4'h0))
                attr_bad++;
            prev_ar_wait = ARVALID && !ARREADY;
            prev_araddr  = ARADDR;
            prev_arlen   = ARLEN;

            // Handshakes completing at the coming rising edge.
            if (cmd_valid && cmd_ready) begin
                accepted = 1;
                chk_err  = 1;
                if (total == 0) exp_done_next = 1;
            end
            if (out_valid && out_ready) got_words.push_back(out_data);
            if (RVALID && RREADY) begin
                rv_hold = 0;
                if (beat_idx == int'(pend_len)) pend = 0;
                else beat_idx++;
                words_seen++;
                if (words_seen == total) exp_done_next = 1;
            end else begin
                rv_hold = RVALID;
            end
            if (ARVALID && ARREADY) begin
                ar_addr_got.push_back(ARADDR);
                ar_len_got.push_back(ARLEN);
                pend = 1; pend_addr = ARADDR; pend_len = ARLEN; beat_idx = 0;
            end
        end

        cmd_valid = 1'b0;
        check("done_pulse_count", 64'(ndone), 64'd1);
        check("done_timing", 64'(done_bad), 64'd0);
        check("ar_count", 64'(ar_addr_got.size()), 64'(v.exp_bursts));
        for (int i = 0; i < ar_addr_got.size() && i < exp_ar_addr.size(); i++) begin
            check("ar_addr", 64'(ar_addr_got[i]), 64'(exp_ar_addr[i]));
            check("ar_len", 64'(ar_len_got[i]), 64'(exp_ar_len[i]));
        end
        check("ar_attrs", 64'(attr_bad), 64'd0);
        check("ar_protocol", 64'(proto_bad), 64'd0);
        check("r_passthrough", 64'(mirror_bad), 64'd0);
        check("word_count", 64'(got_words.size()), 64'(v.exp_words));
        for (int i = 0; i < got_words.size() && i < exp_word_addr.size(); i++) begin
            if (got_words[i] !== data_of(exp_word_addr[i], salt)) word_bad++;
        end
        check("word_data", 64'(word_bad), 64'd0);
        check("err_at_done", 64'(err_at_done), 64'(v.exp_err));
    endtask

    vec_t vecs[$];

    initial begin
        cmd_valid = 1'b0; cmd_addr_start = '0; cmd_addr_end = '0;
        ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0;
        RVALID = 1'b1; out_ready = 1'b1;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {ARVALID, RREADY, out_valid, done, err}, 5'b0);
        @(negedge clk);
        rst = 1'b0; RVALID = 1'b0;
        #1;
        check("reset_cmd_ready", 64'(cmd_ready), 64'd1);

        //                start          end            ar   rv   or ek eb rb bursts words err
        vecs.push_back(mk(32'h0000_1000, 32'h0000_1010, 100, 100, 0, 0, 0, -1, 1, 4,  0));
        vecs.push_back(mk(32'h0000_0FF8, 32'h0000_1048, 100, 100, 0, 0, 0, -1, 3, 20, 0));
        vecs.push_back(mk(32'h0000_2000, 32'h0000_2000, 100, 100, 0, 0, 0, -1, 0, 0,  0));
        vecs.push_back(mk(32'h0000_4000, 32'h0000_4020, 100, 100, 1, 0, 0, -1, 1, 8,  0));
        vecs.push_back(mk(32'h0000_5000, 32'h0000_5010, 100, 100, 0, 1, 1, -1, 1, 4,  1));
        vecs.push_back(mk(32'h0000_5000, 32'h0000_5010, 100, 100, 0, 0, 0, -1, 1, 4,  0));
        vecs.push_back(mk(32'h0000_6000, 32'h0000_6040, 60,  70,  2, 2, 5, -1, 1, 16, 1));
        vecs.push_back(mk(32'h0000_7000, 32'h0000_7020, 50,  50,  2, 3, 2, -1, 1, 8,  1));
        vecs.push_back(mk(32'h0000_3000, 32'h0000_3040, 100, 100, 0, 0, 0, 2,  0, 0,  0));
        vecs.push_back(mk(32'h0000_1000, 32'h0000_1010, 100, 100, 0, 0, 0, -1, 1, 4,  0));
        vecs.push_back(mk(32'h0000_9000, 32'h0000_8000, 100, 100, 0, 0, 0, -1, 0, 0,  0));
        vecs.push_back(mk(32'hFFFF_FFF0, 32'hFFFF_FFFC, 100, 100, 0, 0, 0, -1, 1, 3,  0));
        vecs.push_back(mk(32'h0000_1002, 32'h0000_100A, 100, 100, 0, 0, 0, -1, 1, 2,  0));
        vecs.push_back(mk(32'h0000_1000, 32'h0000_1002, 100, 100, 0, 0, 0, -1, 0, 0,  0));
        vecs.push_back(mk(32'h0000_0000, 32'h0000_0100, 40,  60,  2, 0, 0, -1, 4, 64, 0));
        vecs.push_back(mk(32'h0000_0FC0, 32'h0000_1100, 70,  80,  1, 0, 0, -1, 5, 80, 0));
        vecs.push_back(mk(32'hFFFF_FFF8, 32'hFFFF_FFFF, 100, 100, 0, 0, 0, -1, 1, 1,  0));

        for (int i = 0; i < vecs.size(); i++) begin
            run_xfer(vecs[i], 32'h1000_0000 + 32'(i));
        end

        for (int n = 0; n < 30; n++) begin
            vec_t        v;
            logic [31:0] s, e;
            int          kind, nw;
            case ($urandom_range(2))
                0:       s = 32'h0000_1000 - 32'($urandom_range(120));
                1:       s = $urandom;
                default: s = 32'hFFFF_FF00 + 32'($urandom_range(255));
            endcase
            e    = s + 32'($urandom_range(400));
            kind = $urandom_range(3);
            model(s, e);
            nw   = exp_word_addr.size();
            v = mk(s, e, $urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(2),
                   kind, (nw > 0) ? $urandom_range(nw - 1) : 0, -1,
                   exp_ar_addr.size(), nw, (kind != 0) && (nw > 0));
            run_xfer(v, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
